// File: rtl/vram_dma_pkg.sv
// Shared types and constants for the CGB VRAM DMA controller.
// HDMA1..HDMA5 register offsets, block geometry and FSM states.
package vram_dma_pkg;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [6:0] LEN_DONE    = 7'h7F;

  localparam logic [2:0] REG_HDMA1 = 3'd1;
  localparam logic [2:0] REG_HDMA2 = 3'd2;
  localparam logic [2:0] REG_HDMA3 = 3'd3;
  localparam logic [2:0] REG_HDMA4 = 3'd4;
  localparam logic [2:0] REG_HDMA5 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_G_RD,
    S_G_WR,
    S_H_WAIT,
    S_H_RD,
    S_H_WR,
    S_H_LINE
  } state_e;

endpackage

// File: rtl/vram_dma_ctrl.sv
// CGB VRAM DMA controller: GDMA/HDMA block copies from the
// system bus into VRAM, stalling the CPU while bytes move.
module vram_dma_ctrl
  import vram_dma_pkg::*;
#(
  parameter int BLOCK_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        cgb,
  input  logic [2:0]  reg_sel,
  input  logic        reg_write,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  input  logic        lcd_on,
  input  logic        hblank,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic        src_read,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_write,
  output logic        cpu_stall
);

  localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);

  state_e      state_q, state_d;
  logic [11:0] src_sh_q, src_sh_d;
  logic [8:0]  dst_sh_q, dst_sh_d;
  logic [15:0] src_q, src_d;
  logic [12:0] dst_q, dst_d;
  logic [6:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hb_q, hb_d;
  logic        term_q, term_d;
  logic [7:0]  wdat_q, wdat_d;

  logic wr5, stop, hb_rise, rd, wr;

  assign rd = (state_q == S_G_RD) || (state_q == S_H_RD);
  assign wr = (state_q == S_G_WR) || (state_q == S_H_WR);

  always_comb begin
    state_d  = state_q;
    src_sh_d = src_sh_q;
    dst_sh_d = dst_sh_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    term_d   = term_q;
    wdat_d   = wr ? src_rdata : wdat_q;
    hb_d     = hblank;
    wr5      = cgb && reg_write && (reg_sel == REG_HDMA5);
    stop     = wr5 && !reg_wdata[7];
    hb_rise  = hblank && !hb_q;

    if (cgb && reg_write) begin
      case (reg_sel)
        REG_HDMA1: src_sh_d[11:4] = reg_wdata;
        REG_HDMA2: src_sh_d[3:0]  = reg_wdata[7:4];
        REG_HDMA3: dst_sh_d[8:4]  = reg_wdata[4:0];
        REG_HDMA4: dst_sh_d[3:0]  = reg_wdata[7:4];
        default: ;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        term_d = 1'b0;
        if (wr5) begin
          len_d   = reg_wdata[6:0];
          src_d   = {src_sh_q, 4'h0};
          dst_d   = {dst_sh_q, 4'h0};
          cnt_d   = 4'd0;
          state_d = reg_wdata[7] ? S_H_WAIT : S_G_RD;
        end
      end
      S_G_RD: state_d = S_G_WR;
      S_G_WR, S_H_WR: begin
        src_d = src_q + 16'd1;
        dst_d = dst_q + 13'd1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          if (len_q == 7'd0) begin
            len_d   = LEN_DONE;
            state_d = S_IDLE;
          end else begin
            len_d   = len_q - 7'd1;
            state_d = (state_q == S_G_WR) ? S_G_RD : S_H_LINE;
          end
        end else begin
          state_d = (state_q == S_G_WR) ? S_G_RD : S_H_RD;
        end
        // a terminate seen during the read lands here
        if ((state_q == S_H_WR) && (term_q || stop))
          state_d = S_IDLE;
      end
      S_H_WAIT: begin
        if (stop)
          state_d = S_IDLE;
        else if (hb_rise || !lcd_on)
          state_d = S_H_RD;
      end
      S_H_RD: begin
        state_d = S_H_WR;
        if (stop) term_d = 1'b1;
      end
      S_H_LINE: begin
        if (stop)
          state_d = S_IDLE;
        else if (!hblank || !lcd_on)
          state_d = S_H_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    if (!cgb) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      src_sh_q <= '0;
      dst_sh_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= LEN_DONE;
      cnt_q    <= '0;
      hb_q     <= 1'b0;
      term_q   <= 1'b0;
      wdat_q   <= '0;
    end else if (cpu_en) begin
      state_q  <= state_d;
      src_sh_q <= src_sh_d;
      dst_sh_q <= dst_sh_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hb_q     <= hb_d;
      term_q   <= term_d;
      wdat_q   <= wdat_d;
    end
  end

  assign src_read   = rd;
  assign src_addr   = src_q;
  assign vram_write = wr;
  assign vram_addr  = dst_q;
  assign vram_wdata = wr ? src_rdata : wdat_q;
  assign cpu_stall  = rd || wr;
  assign reg_rdata  = (reg_sel == REG_HDMA5)
                    ? {state_q == S_IDLE, len_q}
                    : 8'hFF;

endmodule
